// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Program counter and instruction fetch sequencer for the 4-bit CPU.
//            Optional macro IF_HALT_EN: opcode 4'hF stops fetching until reset.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic [3:0]         opcode,
  output logic [3:0]         imm,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jmp_sel,
  input  logic [PC_W-1:0]    jmp_target,
  output logic               halted
);

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    REQ        = 2'd1,
    PRESENT    = 2'd2
`ifdef IF_HALT_EN
    , HALT     = 2'd3
`endif
  } state_t;

`ifdef IF_HALT_EN
  localparam logic [3:0] c_OP_HALT = 4'b1111;
  logic r_halted;
`endif

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_req;
  logic            r_valid;
  logic [3:0]      r_opcode;
  logic [3:0]      r_imm;
  logic [PC_W-1:0] r_instr_pc;
  logic [PC_W-1:0] w_next_pc;

  assign w_next_pc = jmp_sel ? jmp_target : r_pc + PC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RESET_WAIT;
      r_pc       <= '0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_opcode   <= 4'h0;
      r_imm      <= 4'h0;
      r_instr_pc <= '0;
`ifdef IF_HALT_EN
      r_halted   <= 1'b0;
`endif
    end else begin
      case (r_state)
        // Any ack seen here is a leftover from before reset and is dropped.
        RESET_WAIT: begin
          r_req   <= 1'b1;
          r_state <= REQ;
        end
        REQ: begin
          if (mem_ack) begin
            r_opcode   <= mem_rdata[INSTR_W-1 -: 4];
            r_imm      <= mem_rdata[3:0];
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_req      <= 1'b0;
            r_state    <= PRESENT;
          end
        end
        PRESENT: begin
          if (instr_ready) begin
            r_pc    <= w_next_pc;
            r_valid <= 1'b0;
`ifdef IF_HALT_EN
            if (r_opcode == c_OP_HALT) begin
              r_halted <= 1'b1;
              r_state  <= HALT;
            end else
`endif
            begin
              r_req   <= 1'b1;
              r_state <= REQ;
            end
          end
        end
`ifdef IF_HALT_EN
        HALT: r_state <= HALT;
`endif
        default: r_state <= RESET_WAIT;
      endcase
    end
  end

  // pc only moves on the accept edge, so the address is stable while requesting.
  assign mem_req     = r_req;
  assign mem_addr    = r_pc;
  assign opcode      = r_opcode;
  assign imm         = r_imm;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
`ifdef IF_HALT_EN
  assign halted      = r_halted;
`else
  assign halted      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch against a transaction-level
//            pc / cycle model. Honours IF_HALT_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_req;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [3:0] opcode;
  logic [3:0] imm;
  logic [3:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       jmp_sel;
  logic [3:0] jmp_target;
  logic       halted;

  int tests = 0;
  int fails = 0;
  int m_pc  = 0;

  instr_fetch #(.PC_W(4), .INSTR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .opcode     (opcode),
    .imm        (imm),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jmp_sel    (jmp_sel),
    .jmp_target (jmp_target),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},    32'(mem_req),     0);
    check({tag, "_addr"},   32'(mem_addr),    0);
    check({tag, "_opcode"}, 32'(opcode),      0);
    check({tag, "_imm"},    32'(imm),         0);
    check({tag, "_ipc"},    32'(instr_pc),    0);
    check({tag, "_valid"},  32'(instr_valid), 0);
    check({tag, "_halted"}, 32'(halted),      0);
  endtask

  function automatic logic [7:0] rand_word();
    logic [7:0] w;
    w = 8'($urandom);
`ifdef IF_HALT_EN
    if (w[7:4] == 4'hF) w[7:4] = 4'h7;
`endif
    return w;
  endfunction

  // One full instruction: entered on the first REQ cycle, left on the next one.
  task automatic do_instr(input logic [7:0] word, input int d, input int r,
                          input logic jsel, input logic [3:0] jt);
    check("req_start",  32'(mem_req),     1);
    check("addr_start", 32'(mem_addr),    32'(m_pc));
    check("valid_req",  32'(instr_valid), 0);
    for (int i = 0; i < d; i++) begin
      mem_ack = 1'b0; mem_rdata = 8'($urandom);
      tick();
      check("req_hold",    32'(mem_req),     1);
      check("addr_stable", 32'(mem_addr),    32'(m_pc));
      check("valid_early", 32'(instr_valid), 0);
    end
    mem_ack = 1'b1; mem_rdata = word;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'($urandom);
    check("valid_rise", 32'(instr_valid), 1);
    check("opcode",     32'(opcode),      32'(word[7:4]));
    check("imm",        32'(imm),         32'(word[3:0]));
    check("instr_pc",   32'(instr_pc),    32'(m_pc));
    check("req_drop",   32'(mem_req),     0);
    for (int i = 0; i < r; i++) begin
      instr_ready = 1'b0; jmp_sel = 1'($urandom); jmp_target = 4'($urandom);
      mem_ack = 1'($urandom);
      tick();
      check("valid_hold", 32'(instr_valid), 1);
      check("op_hold",    32'({opcode, imm}), 32'(word));
      check("ipc_hold",   32'(instr_pc),    32'(m_pc));
      check("no_req",     32'(mem_req),     0);
    end
    mem_ack = 1'b0; instr_ready = 1'b1; jmp_sel = jsel; jmp_target = jt;
    tick();
    instr_ready = 1'b0; jmp_sel = 1'($urandom); jmp_target = 4'($urandom);
    m_pc = jsel ? int'(jt) : (m_pc + 1) % 16;
`ifdef IF_HALT_EN
    if (word[7:4] == 4'hF) begin
      check("halt_flag",  32'(halted),      1);
      check("halt_req",   32'(mem_req),     0);
      check("halt_valid", 32'(instr_valid), 0);
    end else
`endif
    begin
      check("next_req",   32'(mem_req),     1);
      check("next_addr",  32'(mem_addr),    32'(m_pc));
      check("valid_clr",  32'(instr_valid), 0);
      check("not_halted", 32'(halted),      0);
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    instr_ready = 1'b0; jmp_sel = 1'b0; jmp_target = 4'h0;
    repeat (2) tick();
    check_reset("rst");

    rst_n = 1'b1; m_pc = 0;
    tick();
    do_instr(8'h4A, 0, 0, 1'b0, 4'h0);
    do_instr(rand_word(), 3, 2, 1'b0, 4'h0);

    // jumps around pc=5
    do_instr(rand_word(), 0, 1, 1'b1, 4'h5);
    do_instr(rand_word(), 1, 0, 1'b1, 4'h2);
    do_instr(rand_word(), 0, 0, 1'b1, 4'h5);
    do_instr(rand_word(), 2, 3, 1'b0, 4'h9);

    // wrap 14, 15, 0, 1
    do_instr(rand_word(), 0, 0, 1'b1, 4'hE);
    for (int k = 0; k < 3; k++) do_instr(rand_word(), 0, 0, 1'b0, 4'h0);

    for (int k = 0; k < 30; k++)
      do_instr(rand_word(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               1'($urandom), 4'($urandom));

    do_instr(8'hF0, 0, 0, 1'b0, 4'h0);
`ifdef IF_HALT_EN
    for (int k = 0; k < 20; k++) begin
      mem_ack = 1'($urandom); instr_ready = 1'b1;
      tick();
      check("halt_stay_req",  32'(mem_req), 0);
      check("halt_stay_flag", 32'(halted),  1);
    end
    instr_ready = 1'b0; mem_ack = 1'b0;
`endif

    // reset, release with a stray ack held high
    rst_n = 1'b0; #2;
    check_reset("rst2");
    mem_ack = 1'b1;
    tick(); tick();
    rst_n = 1'b1; m_pc = 0;
    tick();
    check("stray_req",   32'(mem_req),     1);
    check("stray_valid", 32'(instr_valid), 0);
    mem_ack = 1'b0;

    // reset during REQ
    tick();
    rst_n = 1'b0; #2;
    check_reset("rst_req");
    mem_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("rreq_req",   32'(mem_req),     1);
    check("rreq_valid", 32'(instr_valid), 0);
    check("rreq_addr",  32'(mem_addr),    0);

    // reset during PRESENT
    mem_rdata = 8'h93;
    tick();
    mem_ack = 1'b0;
    check("pres_valid", 32'(instr_valid), 1);
    check("pres_op",    32'(opcode),      9);
    rst_n = 1'b0; #2;
    check_reset("rst_pres");
    mem_ack = 1'b1; instr_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("rpres_req",   32'(mem_req),     1);
    check("rpres_valid", 32'(instr_valid), 0);
    mem_ack = 1'b0; instr_ready = 1'b0; m_pc = 0;
    do_instr(rand_word(), 1, 1, 1'b0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer for the 4-bit CPU. It owns the program counter, reads 8-bit instruction words from instruction memory over a req/ack handshake, and presents the opcode and immediate fields to the control unit with a valid/ready handshake. It takes the control unit's jump decision and target to choose the next fetch address. It is the producer of the opcode stream that the control unit decodes.

## Interface
Parameters:
- PC_W, 4, program counter and memory address width
- INSTR_W, 8, instruction word width; bits [7:4] are the opcode, bits [3:0] are the immediate/operand

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  PC_W  fetch address; equals pc whenever mem_req=1
- mem_rdata  in  INSTR_W  instruction word; sampled on the edge where mem_ack=1
- mem_ack  in  1  memory completion; may assert in the same cycle as mem_req or any later cycle
- opcode  out  4  registered opcode field, to the control unit
- imm  out  4  registered immediate field
- instr_pc  out  PC_W  address the presented instruction was fetched from
- instr_valid  out  1  opcode, imm and instr_pc hold a valid instruction
- instr_ready  in  1  core accepts the instruction this cycle
- jmp_sel  in  1  control-unit jump decision; sampled only on the accept edge
- jmp_target  in  PC_W  jump destination; sampled only on the accept edge
- halted  out  1  fetch stopped by HALT (see Configuration)

## Operation
- States: RESET_WAIT, REQ, PRESENT, HALT.
- RESET_WAIT: entered asynchronously while rst_n=0. First rising edge with rst_n=1 goes to REQ.
- REQ: mem_req=1 and mem_addr=pc. On an edge with mem_ack=1:
  - register mem_rdata into opcode/imm and pc into instr_pc
  - set instr_valid=1
  - go to PRESENT
- PRESENT: mem_req=0. Outputs hold stable until an edge with instr_ready=1. On that accept edge:
  - pc is set to jmp_target if jmp_sel=1, otherwise pc+1 modulo 2^PC_W (15 wraps to 0)
  - instr_valid clears
  - next state is REQ, or HALT when the HALT condition applies
- HALT: mem_req=0, instr_valid=0, halted=1. Only reset exits HALT.
- mem_ack outside REQ is ignored. mem_rdata outside the ack edge is don't-care.
- jmp_sel and jmp_target are ignored when not on an accept edge.
- Reset mid-operation, including mid-request or mid-present:
  - drops mem_req and instr_valid immediately
  - any late mem_ack after reset release, before REQ is re-entered, is ignored

## Timing
- Reset values: mem_req=0, mem_addr=0, opcode=0, imm=0, instr_pc=0, instr_valid=0, halted=0; internal pc=0.
- mem_req rises on the first edge after reset release.
- Zero-wait memory (ack in the request cycle): instr_valid rises 1 edge after mem_req rises.
- Throughput with zero-wait memory and instr_ready held high: one instruction per 2 cycles.
- Each cycle of ack delay adds 1 cycle. Each cycle instr_ready is low in PRESENT adds 1 cycle.
- Next mem_req/mem_addr appear in the cycle immediately after the accept edge. No speculative fetch occurs.
- mem_addr is registered and must not change while mem_req=1.

## Configuration
- Macro: IF_HALT_EN.
- Defined: accepting an instruction with opcode 4'b1111 enters HALT after the accept edge, with halted=1 and no further mem_req.
- Not defined: opcode 4'b1111 is an ordinary instruction, the HALT state is absent, and halted is tied to 0.

## Test plan
- Reset then release, zero-wait memory returning 8'h4A at address 0, instr_ready=1 -> mem_req=1 addr=0 at cycle 1; instr_valid=1, opcode=4'h4, imm=4'hA, instr_pc=0 at cycle 2; mem_addr=1 at cycle 3.
- Ack delayed 3 cycles, then instr_ready low 2 cycles -> mem_addr stable while req=1; outputs stable while valid and not ready; next req exactly one cycle after the accept edge.
- Accept the instruction at pc=5 with jmp_sel=1, jmp_target=2 -> next mem_addr=2. Same case with jmp_sel=0 -> next mem_addr=6. Toggling jmp_sel outside the accept edge has no effect.
- Run sequentially from pc=14 -> addresses 14, 15, 0, 1 with instr_pc matching each.
- With IF_HALT_EN, accept word 8'hF0 -> halted=1 and mem_req stays 0 for 20 cycles. Without the macro, the same word is followed by a fetch at pc+1.
- Assert rst_n low while in REQ and while in PRESENT -> all outputs return to reset values asynchronously; a stray mem_ack after release does not produce instr_valid before the new request.
